alu_ctrl_pipe: RTL and testbench
================================

ALU_CTRL_PIPE -- requirements
Module: alu_ctrl_pipe

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-002 SHALL have ports: in_valid  in  1  upstream decode fields valid.
REQ-003 SHALL have ports: in_ready  out  1  entry free; a transfer occurs when in_valid & in_ready.
REQ-004 SHALL have ports: Opcode  in  7  instr[6:0]; Funct3  in  3  instr[14:12]; Funct7  in  7  instr[31:25].
REQ-005 SHALL have ports: flush  in  1  discard all buffered and incoming entries.
REQ-006 SHALL have ports: out_valid  out  1  head entry valid; out_ready  in  1  ALU stage accepts head.
REQ-007 SHALL have ports: Operation  out  4  ALU operation code of head entry; illegal  out  1  head entry is undecodable.

Function
REQ-008 SHALL buffer decoded entries {Operation, illegal} in a 2-entry FIFO; count range 0..2.
REQ-009 SHALL drive in_ready = (count < 2), combinationally from registered count only; no dependency on out_ready.
REQ-010 SHALL push on in_valid & in_ready, pop on out_valid & out_ready; simultaneous push and pop keeps count unchanged and preserves order.
REQ-011 SHALL decode at push time; latency accept-to-out_valid exactly 1 cycle when FIFO empty.
REQ-012 SHALL drive out_valid = (count > 0); Operation/illegal SHALL reflect the head entry and read 4'b0000/0 when empty.
REQ-013 SHALL keep Operation/illegal stable while out_valid & !out_ready.
REQ-014 SHALL decode R-type (0110011): f3 000 f7 0000000 ADD 0010; f3 000 f7 0100000 SUB 0011; 111 AND 0000; 110 OR 0001; 100 XOR 0110; 001 SLL 0100; 101 f7 0000000 SRL 0101; 101 f7 0100000 SRA 0111; 010 SLT 1100; any other f3/f7 pair illegal.
REQ-015 SHALL decode I-type ALU (0010011): 000 ADDI 0010; 010 SLTI 1100; 111 0000; 110 0001; 100 0110; 001 (f7=0000000) 0100; 101 f7 0000000 0101, 0100000 0111; other shift f7 illegal; f3 011 illegal.
REQ-016 SHALL decode load 0000011, store 0100011, JALR 1100111 as 0010 regardless of Funct3/Funct7.
REQ-017 SHALL decode branch 1100011: f3 000 1000; 001 1001; 100 1010; 101 1011; other f3 illegal.
REQ-018 SHALL decode LUI 0110111 and JAL 1101111 as 1111.
REQ-019 SHALL encode every illegal entry as Operation 0000, illegal 1; all legal entries illegal 0.
REQ-020 SHALL on flush set count to 0 at the next edge; any push or pop in the flush cycle is discarded; flush has priority over push/pop.
REQ-021 SHALL wrap read/write pointers modulo 2.

Reset
REQ-022 SHALL on reset at a rising edge clear count and pointers: out_valid 0, Operation 0000, illegal 0, in_ready 1 in the following cycle.
REQ-023 SHALL give reset priority over flush, push and pop; reset mid-transfer discards all entries.
REQ-024 SHALL leave FIFO storage contents don't-care after reset, never visible on outputs.

Verification
REQ-025 Push Opcode 0110011/f3 000/f7 0100000, out_ready 1 -> next cycle out_valid 1, Operation 0011, illegal 0; following cycle out_valid 0.
REQ-026 out_ready 0, push ADDI then BNE -> in_ready 0 after second push; third in_valid ignored; release out_ready -> 0010 then 1001 on consecutive cycles, in_ready 1 again.
REQ-027 Push 0010011 f3 101 f7 0100000 then f7 0000001 -> Operation 0111 illegal 0, then Operation 0000 illegal 1.
REQ-028 Full FIFO, assert flush with in_valid 1 -> next cycle out_valid 0, count 0, in_ready 1; flushed entry never appears.
REQ-029 Count 1, push and pop same cycle -> count stays 1, new head is pushed entry (LUI -> 1111).
REQ-030 Count 2, assert reset -> next cycle out_valid 0, Operation 0000, illegal 0, in_ready 1.

Source files
------------

// File: rtl/alu_ctrl_pipe_if.sv
// Decode-to-ALU handshake bundle: upstream decode fields in, buffered ALU control out.
interface alu_ctrl_pipe_if;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] Opcode;
    logic [2:0] Funct3;
    logic [6:0] Funct7;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] Operation;
    logic       illegal;

    modport master (
        output in_valid, Opcode, Funct3, Funct7, flush, out_ready,
        input  in_ready, out_valid, Operation, illegal
    );

    modport slave (
        input  in_valid, Opcode, Funct3, Funct7, flush, out_ready,
        output in_ready, out_valid, Operation, illegal
    );
endinterface

// File: rtl/alu_ctrl_pipe.sv
// ALU control decoder feeding a 2-entry FIFO; each entry holds {illegal, Operation}
// decoded at push time so the ALU stage sees registered control only.
module alu_ctrl_pipe (
    input  logic           clk,
    input  logic           reset,
    alu_ctrl_pipe_if.slave bus
);
    logic [3:0] dec_op;
    logic       dec_ill;
    logic [4:0] mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       push;
    logic       pop;

    always_comb begin
        dec_op  = 4'b0000;
        dec_ill = 1'b0;
        case (bus.Opcode)
            7'b0110011: begin
                case (bus.Funct3)
                    3'b000: begin
                        if (bus.Funct7 == 7'b0000000)      dec_op = 4'b0010;
                        else if (bus.Funct7 == 7'b0100000) dec_op = 4'b0011;
                        else                               dec_ill = 1'b1;
                    end
                    3'b101: begin
                        if (bus.Funct7 == 7'b0000000)      dec_op = 4'b0101;
                        else if (bus.Funct7 == 7'b0100000) dec_op = 4'b0111;
                        else                               dec_ill = 1'b1;
                    end
                    default: begin
                        // Remaining R-type ops are only legal with a zero Funct7
                        if (bus.Funct7 != 7'b0000000) dec_ill = 1'b1;
                        else begin
                            case (bus.Funct3)
                                3'b111:  dec_op = 4'b0000;
                                3'b110:  dec_op = 4'b0001;
                                3'b100:  dec_op = 4'b0110;
                                3'b001:  dec_op = 4'b0100;
                                3'b010:  dec_op = 4'b1100;
                                default: dec_ill = 1'b1;
                            endcase
                        end
                    end
                endcase
            end
            7'b0010011: begin
                case (bus.Funct3)
                    3'b000: dec_op = 4'b0010;
                    3'b010: dec_op = 4'b1100;
                    3'b111: dec_op = 4'b0000;
                    3'b110: dec_op = 4'b0001;
                    3'b100: dec_op = 4'b0110;
                    3'b001: begin
                        if (bus.Funct7 == 7'b0000000) dec_op = 4'b0100;
                        else                          dec_ill = 1'b1;
                    end
                    3'b101: begin
                        if (bus.Funct7 == 7'b0000000)      dec_op = 4'b0101;
                        else if (bus.Funct7 == 7'b0100000) dec_op = 4'b0111;
                        else                               dec_ill = 1'b1;
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
            7'b0000011, 7'b0100011, 7'b1100111: dec_op = 4'b0010;
            7'b1100011: begin
                case (bus.Funct3)
                    3'b000:  dec_op = 4'b1000;
                    3'b001:  dec_op = 4'b1001;
                    3'b100:  dec_op = 4'b1010;
                    3'b101:  dec_op = 4'b1011;
                    default: dec_ill = 1'b1;
                endcase
            end
            7'b0110111, 7'b1101111: dec_op = 4'b1111;
            default: dec_ill = 1'b1;
        endcase
    end

    // Handshake: a beat moves on any edge where valid & ready are both high;
    // in_ready depends on registered count only, never on out_ready.
    assign bus.in_ready  = (count < 2'd2);
    assign bus.out_valid = (count != 2'd0);
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;

    assign bus.Operation = bus.out_valid ? mem[rd_ptr][3:0] : 4'b0000;
    assign bus.illegal   = bus.out_valid ? mem[rd_ptr][4]   : 1'b0;

    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: empty entries are masked off the outputs
    always_ff @(posedge clk) begin
        if (push && !reset && !bus.flush) mem[wr_ptr] <= {dec_ill, dec_op};
    end
endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Randomized bench for alu_ctrl_pipe: rule-table decode model plus a queue-based FIFO model.
module tb_alu_ctrl_pipe;
    typedef struct {
        logic [6:0] opc;
        logic [2:0] f3;
        logic       f3_any;
        logic [6:0] f7;
        logic       f7_any;
        logic [3:0] op;
    } rule_t;

    logic clk;
    logic reset;
    alu_ctrl_pipe_if bus();

    alu_ctrl_pipe dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         n_cmp;
    int         n_err;
    rule_t      rules[$];
    logic [4:0] exp_q[$];
    logic [6:0] opc_list[11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h67, 7'h63,
                                 7'h37, 7'h6f, 7'h33, 7'h13, 7'h63};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic add_rule(input logic [6:0] opc, input logic [2:0] f3, input logic f3_any,
                            input logic [6:0] f7, input logic f7_any, input logic [3:0] op);
        rule_t r;
        r.opc = opc; r.f3 = f3; r.f3_any = f3_any; r.f7 = f7; r.f7_any = f7_any; r.op = op;
        rules.push_back(r);
    endtask

    task automatic build_rules();
        add_rule(7'h33, 3'b000, 0, 7'h00, 0, 4'h2);
        add_rule(7'h33, 3'b000, 0, 7'h20, 0, 4'h3);
        add_rule(7'h33, 3'b111, 0, 7'h00, 0, 4'h0);
        add_rule(7'h33, 3'b110, 0, 7'h00, 0, 4'h1);
        add_rule(7'h33, 3'b100, 0, 7'h00, 0, 4'h6);
        add_rule(7'h33, 3'b001, 0, 7'h00, 0, 4'h4);
        add_rule(7'h33, 3'b101, 0, 7'h00, 0, 4'h5);
        add_rule(7'h33, 3'b101, 0, 7'h20, 0, 4'h7);
        add_rule(7'h33, 3'b010, 0, 7'h00, 0, 4'hc);
        add_rule(7'h13, 3'b000, 0, 7'h00, 1, 4'h2);
        add_rule(7'h13, 3'b010, 0, 7'h00, 1, 4'hc);
        add_rule(7'h13, 3'b111, 0, 7'h00, 1, 4'h0);
        add_rule(7'h13, 3'b110, 0, 7'h00, 1, 4'h1);
        add_rule(7'h13, 3'b100, 0, 7'h00, 1, 4'h6);
        add_rule(7'h13, 3'b001, 0, 7'h00, 0, 4'h4);
        add_rule(7'h13, 3'b101, 0, 7'h00, 0, 4'h5);
        add_rule(7'h13, 3'b101, 0, 7'h20, 0, 4'h7);
        add_rule(7'h03, 3'b000, 1, 7'h00, 1, 4'h2);
        add_rule(7'h23, 3'b000, 1, 7'h00, 1, 4'h2);
        add_rule(7'h67, 3'b000, 1, 7'h00, 1, 4'h2);
        add_rule(7'h63, 3'b000, 0, 7'h00, 1, 4'h8);
        add_rule(7'h63, 3'b001, 0, 7'h00, 1, 4'h9);
        add_rule(7'h63, 3'b100, 0, 7'h00, 1, 4'ha);
        add_rule(7'h63, 3'b101, 0, 7'h00, 1, 4'hb);
        add_rule(7'h37, 3'b000, 1, 7'h00, 1, 4'hf);
        add_rule(7'h6f, 3'b000, 1, 7'h00, 1, 4'hf);
    endtask

    // Returns {illegal, Operation}; anything matching no rule is illegal with op 0
    function automatic logic [4:0] ref_decode(input logic [6:0] opc, input logic [2:0] f3,
                                              input logic [6:0] f7);
        foreach (rules[i]) begin
            if (rules[i].opc == opc && (rules[i].f3_any || rules[i].f3 == f3) &&
                (rules[i].f7_any || rules[i].f7 == f7))
                return {1'b0, rules[i].op};
        end
        return 5'b10000;
    endfunction

    task automatic check_outputs();
        logic [4:0] head;
        head = (exp_q.size() > 0) ? exp_q[0] : 5'b00000;
        check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() > 0));
        check("in_ready",  32'(bus.in_ready),  32'(exp_q.size() < 2));
        check("operation", 32'(bus.Operation), 32'(head[3:0]));
        check("illegal",   32'(bus.illegal),   32'(head[4]));
    endtask

    // One clock: capture inputs, advance the model, then compare just after the edge
    task automatic cycle();
        logic       rs, fl, iv, ordy, do_pop, do_push;
        logic [4:0] dec;
        rs   = reset;
        fl   = bus.flush;
        iv   = bus.in_valid;
        ordy = bus.out_ready;
        dec  = ref_decode(bus.Opcode, bus.Funct3, bus.Funct7);
        @(posedge clk);
        #1;
        if (rs || fl) begin
            exp_q.delete();
        end else begin
            do_pop  = (exp_q.size() > 0) && ordy;
            do_push = (exp_q.size() < 2) && iv;
            if (do_pop)  void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(dec);
        end
        check_outputs();
    endtask

    task automatic set_in(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                          input logic [6:0] f7);
        bus.in_valid = v;
        bus.Opcode   = opc;
        bus.Funct3   = f3;
        bus.Funct7   = f7;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        build_rules();
        reset         = 1'b1;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        set_in(0, 7'h00, 3'b000, 7'h00);
        cycle();
        cycle();
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        reset = 1'b0;

        // SUB with ALU ready: one-cycle latency, then drains
        bus.out_ready = 1'b1;
        set_in(1, 7'h33, 3'b000, 7'h20);
        cycle();
        check("sub_op", 32'(bus.Operation), 32'h3);
        check("sub_valid", 32'(bus.out_valid), 32'd1);
        set_in(0, 7'h00, 3'b000, 7'h00);
        cycle();
        check("sub_drain", 32'(bus.out_valid), 32'd0);

        // Backpressure: ADDI, BNE fill the FIFO, third beat ignored, then drain in order
        bus.out_ready = 1'b0;
        set_in(1, 7'h13, 3'b000, 7'h55);
        cycle();
        set_in(1, 7'h63, 3'b001, 7'h00);
        cycle();
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        set_in(1, 7'h37, 3'b000, 7'h00);
        cycle();
        check("stall_op", 32'(bus.Operation), 32'h2);
        set_in(0, 7'h00, 3'b000, 7'h00);
        bus.out_ready = 1'b1;
        cycle();
        check("drain_bne", 32'(bus.Operation), 32'h9);
        cycle();
        check("drain_empty", 32'(bus.in_ready), 32'd1);

        // SRAI legal, shift with bad Funct7 illegal
        set_in(1, 7'h13, 3'b101, 7'h20);
        cycle();
        check("srai_op", 32'(bus.Operation), 32'h7);
        set_in(1, 7'h13, 3'b101, 7'h01);
        cycle();
        check("bad_shift_ill", 32'(bus.illegal), 32'd1);
        check("bad_shift_op", 32'(bus.Operation), 32'h0);
        set_in(0, 7'h00, 3'b000, 7'h00);
        cycle();

        // Flush of a full FIFO also drops the incoming beat
        bus.out_ready = 1'b0;
        set_in(1, 7'h33, 3'b111, 7'h00);
        cycle();
        cycle();
        bus.flush = 1'b1;
        set_in(1, 7'h6f, 3'b000, 7'h00);
        cycle();
        check("flush_valid", 32'(bus.out_valid), 32'd0);
        check("flush_ready", 32'(bus.in_ready), 32'd1);
        bus.flush = 1'b0;
        set_in(0, 7'h00, 3'b000, 7'h00);
        cycle();
        check("flush_stays_empty", 32'(bus.out_valid), 32'd0);

        // Simultaneous push/pop at count 1
        set_in(1, 7'h33, 3'b000, 7'h00);
        cycle();
        bus.out_ready = 1'b1;
        set_in(1, 7'h37, 3'b000, 7'h00);
        cycle();
        check("pp_op", 32'(bus.Operation), 32'hf);
        check("pp_count1", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b0;
        set_in(0, 7'h00, 3'b000, 7'h00);
        cycle();

        // Reset at count 2
        set_in(1, 7'h03, 3'b010, 7'h00);
        cycle();
        reset = 1'b1;
        set_in(1, 7'h63, 3'b000, 7'h00);
        cycle();
        check("rst_full_valid", 32'(bus.out_valid), 32'd0);
        check("rst_full_op", 32'(bus.Operation), 32'h0);
        reset = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            logic [6:0] opc;
            logic [6:0] f7;
            opc = ($urandom_range(0, 7) == 0) ? 7'($urandom) : opc_list[$urandom_range(0, 10)];
            case ($urandom_range(0, 3))
                0, 1:    f7 = 7'h00;
                2:       f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
            set_in($urandom_range(0, 3) != 0, opc, 3'($urandom), f7);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.flush     = ($urandom_range(0, 39) == 0);
            reset         = ($urandom_range(0, 199) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
